// File: rtl/lcd_text_ctrl.sv
// HD44780 character-LCD controller: ROWS x COLS framebuffer, power-on init, endless panel refresh.
// Latency: host write visible on the next refresh of that cell; first strobe PWR_WAIT_CYC+SETUP_CYC after reset.
// Backpressure: busy=1 during a clear sweep, host writes and clear requests are dropped meanwhile.
module lcd_text_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int SETUP_CYC    = 2,
  parameter int E_CYC        = 12,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int PWR_WAIT_CYC = 750000,
  parameter int AW           = $clog2(ROWS*COLS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clr_req,
  output logic          busy,
  output logic          init_done,
  output logic          frame_tick,
  output logic          lcdrs,
  output logic          lcdrw,
  output logic          lcde,
  output logic [7:0]    lcddata
);

  localparam int NCHR = ROWS*COLS;
  localparam int IW   = $clog2(NCHR);
  // One counter serves every phase, so it is sized for the sum of all phase lengths.
  localparam int CW   = $clog2(PWR_WAIT_CYC + CLR_WAIT_CYC + CMD_WAIT_CYC +
                               SETUP_CYC + E_CYC + HOLD_CYC + 1);

  typedef enum logic [1:0] {T_PWR, T_INIT, T_REFR} top_t;
  typedef enum logic [1:0] {P_SETUP, P_STROBE, P_HOLD, P_WAIT} ph_t;

  logic [7:0]    fb [NCHR];
  logic [IW-1:0] clr_addr;
  logic          host_wr;

  top_t          top, nxt_top;
  ph_t           ph, nxt_ph;
  logic [CW-1:0] cnt, nxt_cnt, len_m1;
  logic [2:0]    step, nxt_step;
  logic [1:0]    row, nxt_row;
  logic [4:0]    col, nxt_col;   // 0 = row address command, 1..COLS = characters
  logic          load, init_end, frame_end;
  logic          xfer_rs;
  logic [7:0]    xfer_dat;
  logic [IW-1:0] rd_idx;

  assign lcdrw   = 1'b0;
  assign host_wr = wr_en && !busy && !clr_req && (int'(wr_addr) < NCHR);

  // Clear sweep control: one location per cycle, restarted by reset or an idle-time clr_req.
  always_ff @(posedge clk) begin
    if (resetn) begin
      busy     <= 1'b1;
      clr_addr <= '0;
    end else if (busy) begin
      clr_addr <= clr_addr + IW'(1);
      if (clr_addr == IW'(NCHR-1)) busy <= 1'b0;
    end else if (clr_req) begin
      busy     <= 1'b1;
      clr_addr <= '0;
    end
  end

  // Framebuffer write port, shared by the sweep and the host (sweep has priority).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if (busy)         fb[clr_addr]         <= 8'h20;
      else if (host_wr) fb[wr_addr[IW-1:0]]  <= wr_data;
    end
  end

  // State register: top sequencer, transfer phase, phase counter and position.
  always_ff @(posedge clk) begin
    if (resetn) begin
      top  <= T_PWR;
      ph   <= P_SETUP;
      cnt  <= '0;
      step <= '0;
      row  <= '0;
      col  <= '0;
    end else begin
      top  <= nxt_top;
      ph   <= nxt_ph;
      cnt  <= nxt_cnt;
      step <= nxt_step;
      row  <= nxt_row;
      col  <= nxt_col;
    end
  end

  // Next state: each phase lasts its length, the end of WAIT selects the next transfer.
  always_comb begin
    nxt_top   = top;
    nxt_ph    = ph;
    nxt_cnt   = cnt + CW'(1);
    nxt_step  = step;
    nxt_row   = row;
    nxt_col   = col;
    load      = 1'b0;
    init_end  = 1'b0;
    frame_end = 1'b0;
    len_m1    = CW'(CMD_WAIT_CYC-1);
    if (top == T_PWR) begin
      len_m1 = CW'(PWR_WAIT_CYC-1);
    end else begin
      case (ph)
        P_SETUP:  len_m1 = CW'(SETUP_CYC-1);
        P_STROBE: len_m1 = CW'(E_CYC-1);
        P_HOLD:   len_m1 = CW'(HOLD_CYC-1);
        default:  len_m1 = (top == T_INIT && step == 3'd5) ? CW'(CLR_WAIT_CYC-1)
                                                           : CW'(CMD_WAIT_CYC-1);
      endcase
    end
    if (cnt == len_m1) begin
      nxt_cnt = '0;
      if (top == T_PWR) begin
        nxt_top  = T_INIT;
        nxt_ph   = P_SETUP;
        nxt_step = '0;
        load     = 1'b1;
      end else begin
        case (ph)
          P_SETUP:  nxt_ph = P_STROBE;
          P_STROBE: nxt_ph = P_HOLD;
          P_HOLD:   nxt_ph = P_WAIT;
          default: begin
            nxt_ph = P_SETUP;
            load   = 1'b1;
            if (top == T_INIT) begin
              if (step == 3'd6) begin
                nxt_top  = T_REFR;
                nxt_row  = '0;
                nxt_col  = '0;
                init_end = 1'b1;
              end else begin
                nxt_step = step + 3'd1;
              end
            end else if (col == 5'(COLS)) begin
              nxt_col = '0;
              if (row == 2'(ROWS-1)) begin
                nxt_row   = '0;
                frame_end = 1'b1;
              end else begin
                nxt_row = row + 2'd1;
              end
            end else begin
              nxt_col = col + 5'd1;
            end
          end
        endcase
      end
    end
  end

  // Outputs: strobe decode, and the value of the transfer about to enter SETUP.
  always_comb begin
    lcde     = (top != T_PWR) && (ph == P_STROBE);
    xfer_rs  = 1'b0;
    xfer_dat = 8'h00;
    rd_idx   = '0;
    if (nxt_top == T_INIT) begin
      case (nxt_step)
        3'd0, 3'd1, 3'd2, 3'd3: xfer_dat = 8'h38;
        3'd4:                   xfer_dat = 8'h0C;
        3'd5:                   xfer_dat = 8'h01;
        default:                xfer_dat = 8'h06;
      endcase
    end else if (nxt_col == 5'd0) begin
      case (nxt_row)
        2'd0:    xfer_dat = 8'h80;
        2'd1:    xfer_dat = 8'hC0;
        2'd2:    xfer_dat = 8'h94;
        default: xfer_dat = 8'hD4;
      endcase
    end else begin
      rd_idx   = IW'(int'(nxt_row)*COLS + int'(nxt_col) - 1);
      xfer_rs  = 1'b1;
      xfer_dat = fb[rd_idx];
    end
  end

  // Bus and status registers: bus value changes only when a transfer enters SETUP.
  always_ff @(posedge clk) begin
    if (resetn) begin
      lcdrs      <= 1'b0;
      lcddata    <= 8'h00;
      init_done  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (init_end) init_done <= 1'b1;
      if (load) begin
        lcdrs   <= xfer_rs;
        lcddata <= xfer_dat;
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: bus monitor decodes strobes into transfers, frames compared to expectations.
// Cycle numbers count posedges; the release edge is the last edge sampled with resetn high,
// so the first strobe of init is seen PWR_WAIT_CYC+SETUP_CYC edges after it.
module tb_lcd_text_ctrl;
  localparam int COLS = 4, ROWS = 2, SETUP = 1, EC = 2, HOLD = 1;
  localparam int CMDW = 4, CLRW = 8, PWRW = 10, AW = 4;
  localparam int N = ROWS*COLS;
  localparam logic [8*N-1:0] SP = {N{8'h20}};

  logic clk = 1'b0, resetn = 1'b1, wr_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0] wr_data = 8'h00;
  logic busy, init_done, frame_tick, lcdrs, lcdrw, lcde;
  logic [7:0] lcddata;

  lcd_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .SETUP_CYC(SETUP), .E_CYC(EC), .HOLD_CYC(HOLD),
                  .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW), .PWR_WAIT_CYC(PWRW), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .init_done(init_done), .frame_tick(frame_tick),
    .lcdrs(lcdrs), .lcdrw(lcdrw), .lcde(lcde), .lcddata(lcddata));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  typedef struct { logic rs; logic [7:0] dat; int rise; int len; bit stable; } xfer_t;
  xfer_t xq[$];
  xfer_t cur;
  logic prev_e = 1'b0, prev_rs = 1'b0, prev_tick = 1'b0, prev_idone = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  int idone_cyc = -1, tick_wide = 0;

  // Bus monitor: one record per strobe, with bus stability from setup through hold.
  always @(negedge clk) begin
    if (resetn) begin
      prev_e = 1'b0; prev_tick = 1'b0; prev_idone = 1'b0; idone_cyc = -1;
    end else begin
      if (lcde && !prev_e) begin
        cur.rs = lcdrs; cur.dat = lcddata; cur.rise = cyc;
        cur.stable = (lcdrs == prev_rs) && (lcddata == prev_dat);
      end else if (lcde || prev_e) begin
        if (lcdrs != cur.rs || lcddata != cur.dat) cur.stable = 1'b0;
      end
      if (!lcde && prev_e) begin
        cur.len = cyc - cur.rise;
        xq.push_back(cur);
      end
      if (frame_tick && prev_tick) tick_wide++;
      if (init_done && !prev_idone) idone_cyc = cyc;
      prev_e = lcde; prev_tick = frame_tick; prev_idone = init_done;
    end
    prev_rs = lcdrs; prev_dat = lcddata;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] init_cmd(input int i);
    case (i)
      4:       return 8'h0C;
      5:       return 8'h01;
      6:       return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

  function automatic logic [7:0] row_cmd(input int r);
    case (r)
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  int tick_at;
  task automatic wait_tick(input int budget);
    int k = 0;
    @(negedge clk);
    while (!frame_tick && k < budget) begin @(negedge clk); k++; end
    tick_at = cyc;
    chk("frame_tick arrival", frame_tick, 1);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (xq.size() < n && k < budget) begin @(negedge clk); k++; end
    chk("transfer arrival", int'(xq.size() >= n), 1);
  endtask

  // Compare one whole frame of bus transfers against the expected characters.
  task automatic check_frame(input logic [8*N-1:0] exp, input string tag);
    logic [7:0] ec;
    xfer_t x;
    wait_tick(400);
    xq.delete();
    wait_tick(400);
    chk({tag, " tick bus"}, {lcdrs, lcde, lcddata}, {2'b00, 8'h80});
    chk({tag, " transfers"}, xq.size(), ROWS*(COLS+1));
    if (xq.size() == ROWS*(COLS+1)) begin
      chk({tag, " tick after last wait"}, tick_at - xq[$].rise, EC + HOLD + CMDW);
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c <= COLS; c++) begin
          x  = xq[r*(COLS+1) + c];
          ec = (c == 0) ? row_cmd(r) : exp[8*N-1 - 8*(r*COLS + c - 1) -: 8];
          chk($sformatf("%s r%0d c%0d rs/data", tag, r, c), {x.rs, x.dat}, {(c != 0), ec});
          chk($sformatf("%s r%0d c%0d e width", tag, r, c), x.len, EC);
          chk($sformatf("%s r%0d c%0d stable", tag, r, c), int'(x.stable), 1);
        end
      end
    end
  endtask

  // Hold reset, check reset outputs, release, then check sweep length and the init sequence.
  task automatic do_reset();
    int rel;
    @(negedge clk);
    resetn = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, init_done, frame_tick, lcdrs, lcdrw, lcde, lcddata},
        {6'b100000, 8'h00});
    resetn = 1'b0;
    rel = cyc;
    xq.delete();
    repeat (N-1) @(negedge clk);
    chk("busy before sweep end", busy, 1);
    @(negedge clk);
    chk("busy after sweep end", busy, 0);
    wait_xfers(8, 400);
    if (xq.size() >= 8) begin
      chk("first strobe cycle", xq[0].rise - rel, PWRW + SETUP);
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("init %0d rs/data", i), {xq[i].rs, xq[i].dat}, {1'b0, init_cmd(i)});
        chk($sformatf("init %0d e width", i), xq[i].len, EC);
        chk($sformatf("init %0d spacing", i), xq[i+1].rise - xq[i].rise,
            SETUP + EC + HOLD + ((i == 5) ? CLRW : CMDW));
      end
      chk("first refresh command", {xq[7].rs, xq[7].dat}, {1'b0, 8'h80});
      chk("init_done rise cycle", idone_cyc, xq[7].rise - SETUP);
    end
  endtask

  typedef struct { logic wr; logic clr; logic [AW-1:0] addr; logic [7:0] dat; logic [8*N-1:0] exp; } vec_t;
  vec_t tbl[7];
  logic [7:0] model [N];
  logic [8*N-1:0] mexp;
  int busy_left, bc, k, r;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd5,  8'h41, {32'h20202020, 32'h20412020}};
    tbl[1] = '{1'b1, 1'b0, 4'd8,  8'h55, {32'h20202020, 32'h20412020}};
    tbl[2] = '{1'b1, 1'b0, 4'd0,  8'h42, {32'h42202020, 32'h20412020}};
    tbl[3] = '{1'b1, 1'b1, 4'd0,  8'h41, SP};
    tbl[4] = '{1'b1, 1'b0, 4'd7,  8'h7A, {32'h20202020, 32'h2020207A}};
    tbl[5] = '{1'b1, 1'b0, 4'd15, 8'h66, {32'h20202020, 32'h2020207A}};
    tbl[6] = '{1'b1, 1'b0, 4'd2,  8'h33, {32'h20203320, 32'h2020207A}};

    do_reset();
    check_frame(SP, "blank frame");

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      wr_en = tbl[i].wr; clr_req = tbl[i].clr; wr_addr = tbl[i].addr; wr_data = tbl[i].dat;
      @(negedge clk);
      wr_en = 1'b0; clr_req = 1'b0;
      check_frame(tbl[i].exp, $sformatf("vector %0d", i));
    end

    // Clear with a simultaneous write, then keep writing while the sweep runs.
    @(negedge clk);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h41;
    @(negedge clk);
    clr_req = 1'b0; wr_addr = 4'd1; wr_data = 8'h5A;
    bc = 0;
    while (busy && bc < 50) begin bc++; @(negedge clk); end
    wr_en = 1'b0;
    chk("clear busy length", bc, N);
    check_frame(SP, "after clear");

    // Random host traffic against the framebuffer model.
    for (int i = 0; i < N; i++) model[i] = 8'h20;
    busy_left = 0;
    for (int round = 0; round < 3; round++) begin
      for (int n = 0; n < 80; n++) begin
        @(negedge clk);
        chk("random busy", busy, int'(busy_left > 0));
        r = $urandom_range(0, 99);
        clr_req = (r < 3);
        wr_en   = (r >= 3 && r < 70) || (r < 3 && $urandom_range(0, 1) == 1);
        wr_addr = AW'($urandom_range(0, 15));
        wr_data = 8'($urandom_range(0, 255));
        if (clr_req && busy_left == 0) begin
          for (int i = 0; i < N; i++) model[i] = 8'h20;
          busy_left = N;
        end else if (busy_left > 0) begin
          busy_left--;
        end else if (wr_en && !clr_req && int'(wr_addr) < N) begin
          model[int'(wr_addr[2:0])] = wr_data;
        end
      end
      @(negedge clk);
      wr_en = 1'b0; clr_req = 1'b0;
      busy_left = 0;
      for (int i = 0; i < N; i++) mexp[8*N-1 - 8*i -: 8] = model[i];
      check_frame(mexp, $sformatf("random %0d", round));
    end

    // Reset while the enable strobe is high.
    k = 0;
    while (!lcde && k < 100) begin @(negedge clk); k++; end
    chk("strobe before reset", lcde, 1);
    chk("init_done before reset", init_done, 1);
    resetn = 1'b1;
    @(negedge clk);
    chk("mid-strobe reset lcde", lcde, 0);
    chk("mid-strobe reset lcddata", lcddata, 0);
    chk("mid-strobe reset init_done", init_done, 0);
    do_reset();
    check_frame(SP, "frame after reset");

    chk("frame_tick single cycle", tick_wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
